// File: rtl/kianv_clint_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kianv_clint_pkg
//  Description : Shared CLINT register offsets, bus FSM states, reset constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package kianv_clint_pkg;

    localparam logic [15:0] MSIP        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

    // Per-byte replace of old_v by new_v wherever strb is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kianv_clint_if.sv
`default_nettype none
// ============================================================================
//  Module      : kianv_clint_if
//  Description : CPU native memory bus (valid/ready) as seen by the CLINT.
//  Revision    : 1.0 - initial release
// ============================================================================
interface kianv_clint_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_wstrb;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        access_fault;

    modport master (
        output mem_valid, mem_wstrb, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata, access_fault
    );

    modport slave (
        input  mem_valid, mem_wstrb, mem_addr, mem_wdata,
        output mem_ready, mem_rdata, access_fault
    );
endinterface
`default_nettype wire

// File: rtl/kianv_clint_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : kianv_clint_prescaler
//  Description : Divides clk by DIV, one-cycle tick when the count hits DIV-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module kianv_clint_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    // DIV=1 keeps a single bit pinned at zero, so tick is asserted every cycle.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/kianv_clint.sv
`default_nettype none
// ============================================================================
//  Module      : kianv_clint
//  Description : Core-local interruptor (msip/mtime/mtimecmp) driving IRQ3/IRQ7.
//                Optional macro KIANV_CLINT_TIME_SNAPSHOT_EN: torn-free mtime
//                lo-then-hi reads through a hi-word snapshot register.
//  Revision    : 1.0 - initial release
// ============================================================================
module kianv_clint
    import kianv_clint_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int TIMER_FREQ_HZ = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    kianv_clint_if.slave       bus,
    output logic               IRQ3,
    output logic               IRQ7
);
    localparam int DIV = CLK_FREQ_HZ / TIMER_FREQ_HZ;

    bus_state_e  r_state;
    bus_state_e  w_state_next;
    logic        w_accept;
    logic        w_is_write;
    logic        w_wr;
    logic        w_mapped;
    logic [31:0] w_rdata;
    logic        w_tick;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_irq7;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_next;

`ifdef KIANV_CLINT_TIME_SNAPSHOT_EN
    logic [31:0] r_snap;
`endif

    kianv_clint_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_accept   = bus.mem_valid && (r_state == ST_IDLE);
    assign w_is_write = |bus.mem_wstrb;
    assign w_wr       = w_accept && w_is_write;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RESP;
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Exact offset compare also rejects unaligned addresses.
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (bus.mem_addr)
            MSIP:        w_rdata = {31'b0, r_msip};
            MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            MTIME_LO:    w_rdata = r_mtime[31:0];
`ifdef KIANV_CLINT_TIME_SNAPSHOT_EN
            MTIME_HI:    w_rdata = r_snap;
`else
            MTIME_HI:    w_rdata = r_mtime[63:32];
`endif
            default: begin
                w_rdata  = '0;
                w_mapped = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_is_write ? 32'h0 : w_rdata;
            r_fault <= ~w_mapped;
        end else begin
            r_rdata <= '0;
            r_fault <= 1'b0;
        end
    end

    assign bus.mem_ready    = (r_state == ST_RESP);
    assign bus.mem_rdata    = r_rdata;
    assign bus.access_fault = r_fault;

    // Written bytes override the tick; untouched bytes keep the incremented value.
    always_comb begin
        w_mtime_inc  = w_tick ? (r_mtime + 64'd1) : r_mtime;
        w_mtime_next = w_mtime_inc;
        if (w_wr && (bus.mem_addr == MTIME_LO))
            w_mtime_next[31:0]  = byte_merge(w_mtime_inc[31:0], bus.mem_wdata, bus.mem_wstrb);
        if (w_wr && (bus.mem_addr == MTIME_HI))
            w_mtime_next[63:32] = byte_merge(w_mtime_inc[63:32], bus.mem_wdata, bus.mem_wstrb);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_msip     <= 1'b0;
            r_irq7     <= 1'b0;
        end else begin
            r_mtime <= w_mtime_next;
            r_irq7  <= (r_mtime >= r_mtimecmp);
            if (w_wr && (bus.mem_addr == MTIMECMP_LO))
                r_mtimecmp[31:0]  <= byte_merge(r_mtimecmp[31:0], bus.mem_wdata, bus.mem_wstrb);
            if (w_wr && (bus.mem_addr == MTIMECMP_HI))
                r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], bus.mem_wdata, bus.mem_wstrb);
            if (w_wr && (bus.mem_addr == MSIP) && bus.mem_wstrb[0])
                r_msip <= bus.mem_wdata[0];
        end
    end

`ifdef KIANV_CLINT_TIME_SNAPSHOT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= '0;
        end else if (w_accept && !w_is_write && (bus.mem_addr == MTIME_LO)) begin
            r_snap <= r_mtime[63:32];
        end
    end
`endif

    assign IRQ3 = r_msip;
    assign IRQ7 = r_irq7;

endmodule
`default_nettype wire

// File: tb/tb_kianv_clint.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kianv_clint
//  Description : Scoreboard bench for kianv_clint; a DIV=4 and a DIV=1 instance.
//                Honours KIANV_CLINT_TIME_SNAPSHOT_EN for the mtime hi read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kianv_clint;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] rdata;
        logic        fault;
        logic        is_read;
    } exp_t;

    logic clk;
    logic reset;
    logic irq3_4, irq7_4, irq3_1, irq7_1;
    int   checks;
    int   errors;
    exp_t q4[$];
    exp_t q1[$];

`ifdef KIANV_CLINT_TIME_SNAPSHOT_EN
    localparam logic [31:0] c_snap_hi = 32'h0;
`else
    localparam logic [31:0] c_snap_hi = 32'h1;
`endif

    kianv_clint_if bus4 ();
    kianv_clint_if bus1 ();

    kianv_clint #(.CLK_FREQ_HZ(50_000_000), .TIMER_FREQ_HZ(12_500_000)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave), .IRQ3(irq3_4), .IRQ7(irq7_4));

    kianv_clint #(.CLK_FREQ_HZ(50_000_000), .TIMER_FREQ_HZ(50_000_000)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .IRQ3(irq3_1), .IRQ7(irq7_1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [15:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (sel) begin
            bus1.mem_valid = v; bus1.mem_addr = a; bus1.mem_wstrb = s; bus1.mem_wdata = d;
        end else begin
            bus4.mem_valid = v; bus4.mem_addr = a; bus4.mem_wstrb = s; bus4.mem_wdata = d;
        end
    endtask

    function automatic logic ready_of(input bit sel);
        return sel ? bus1.mem_ready : bus4.mem_ready;
    endfunction

    // Issue one access: expectation queued, request at negedge, accepted on next posedge.
    task automatic xfer(input bit sel, input logic [15:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] er, input logic ef);
        exp_t e;
        e.addr = a; e.rdata = er; e.fault = ef; e.is_read = (s == 4'b0000);
        if (sel) q1.push_back(e); else q4.push_back(e);
        @(negedge clk);
        drive(sel, 1'b1, a, s, d);
        @(posedge clk); #1;
        check("ready_latency", {31'b0, ready_of(sel)}, 32'h1);
        drive(sel, 1'b0, 16'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        check("ready_one_cycle", {31'b0, ready_of(sel)}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every ready pulse consumes the oldest expectation of that instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus4.mem_ready) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL resp4_unexpected: got ready with empty queue, required none");
            end else begin
                e = q4.pop_front();
                if (bus4.access_fault !== e.fault || (e.is_read && bus4.mem_rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL resp4 addr=%h: got rdata=%h fault=%b expected rdata=%h fault=%b",
                             e.addr, bus4.mem_rdata, bus4.access_fault, e.rdata, e.fault);
                end
            end
        end
        if (bus1.mem_ready) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL resp1_unexpected: got ready with empty queue, required none");
            end else begin
                e = q1.pop_front();
                if (bus1.access_fault !== e.fault || (e.is_read && bus1.mem_rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL resp1 addr=%h: got rdata=%h fault=%b expected rdata=%h fault=%b",
                             e.addr, bus1.mem_rdata, bus1.access_fault, e.rdata, e.fault);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {31'b0, bus4.mem_ready},    32'h0);
        check("rst_rdata",  bus4.mem_rdata,             32'h0);
        check("rst_fault",  {31'b0, bus4.access_fault}, 32'h0);
        check("rst_irq3",   {31'b0, irq3_4},            32'h0);
        check("rst_irq7",   {31'b0, irq7_4},            32'h0);
        check("rst_irq7_1", {31'b0, irq7_1},            32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset values of mtimecmp
        xfer(0, 16'h4004, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        xfer(0, 16'h4000, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        check("irq7_after_reset", {31'b0, irq7_4}, 32'h0);

        // DIV=4: read accepted on edge 41 sees floor(40/4)=10
        do_reset();
        repeat (40) @(posedge clk);
        xfer(0, 16'hBFF8, 4'h0, 32'h0, 32'd10, 1'b0);
        xfer(0, 16'h4004, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer(0, 16'h4000, 4'hF, 32'd12, 32'h0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq7_mtime11", {31'b0, irq7_4}, 32'h0);
        @(posedge clk); #1;
        check("irq7_mtime12", {31'b0, irq7_4}, 32'h1);

        // msip / IRQ3
        xfer(0, 16'h0000, 4'hF, 32'h1, 32'h0, 1'b0);
        check("irq3_set", {31'b0, irq3_4}, 32'h1);
        xfer(0, 16'h0000, 4'h0, 32'h0, 32'h1, 1'b0);
        xfer(0, 16'h0000, 4'hF, 32'h0, 32'h0, 1'b0);
        check("irq3_clr", {31'b0, irq3_4}, 32'h0);
        xfer(0, 16'h0000, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer(0, 16'h0000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer(0, 16'h0000, 4'h0, 32'h0, 32'h1, 1'b0);

        // DIV=1 wrap: mtime FFFFFFFF_FFFFFFFE written on edge b
        xfer(1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer(1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE, 32'h0, 1'b0);
        check("irq7_wrap_pre", {31'b0, irq7_1}, 32'h0);
        @(posedge clk); #1;
        check("irq7_at_max", {31'b0, irq7_1}, 32'h1);
        xfer(1, 16'hBFF8, 4'h0, 32'h0, 32'h0, 1'b0);
        check("irq7_after_wrap", {31'b0, irq7_1}, 32'h0);
        xfer(1, 16'hBFFC, 4'h0, 32'h0, 32'h0, 1'b0);

        // Snapshot: lo read sees FFFFFFFE, carry into hi happens before the hi read
        xfer(1, 16'hBFFC, 4'hF, 32'h0, 32'h0, 1'b0);
        xfer(1, 16'hBFF8, 4'hF, 32'hFFFF_FFFD, 32'h0, 1'b0);
        xfer(1, 16'hBFF8, 4'h0, 32'h0, 32'hFFFF_FFFE, 1'b0);
        xfer(1, 16'hBFFC, 4'h0, 32'h0, c_snap_hi, 1'b0);
        xfer(1, 16'hBFF8, 4'h0, 32'h0, 32'h2, 1'b0);
        xfer(1, 16'hBFFC, 4'h0, 32'h0, 32'h1, 1'b0);

        // Reset with a request pending: no ready, state cleared
        xfer(0, 16'h0000, 4'hF, 32'h1, 32'h0, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 16'h4000, 4'h0, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_pending_ready", {31'b0, bus4.mem_ready}, 32'h0);
        check("rst_irq3_cleared",  {31'b0, irq3_4},         32'h0);
        drive(0, 1'b0, 16'h0, 4'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Byte strobes and faults
        xfer(0, 16'h4000, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
        xfer(0, 16'h4000, 4'h0, 32'h0, 32'hFFFF_ABFF, 1'b0);
        xfer(0, 16'h0100, 4'h0, 32'h0, 32'h0, 1'b1);
        xfer(0, 16'h4002, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
        xfer(0, 16'h4002, 4'h0, 32'h0, 32'h0, 1'b1);
        xfer(0, 16'h4000, 4'h0, 32'h0, 32'hFFFF_ABFF, 1'b0);
        xfer(0, 16'h0100, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer(0, 16'h0000, 4'h0, 32'h0, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("q4_drained", q4.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
